// File: rtl/bus_initiator_if.sv
// Request/response port and daisy-chain bus signals of the bus initiator.
// master is the initiator's view; slave is the host bridge plus chain side.
interface bus_initiator_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
);

  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic                  req_rw_i;
  logic                  req_valid_i;
  logic                  req_ready_o;

  logic [DATA_WIDTH-1:0] resp_rdata_o;
  logic                  resp_rw_o;
  logic                  resp_timeout_o;
  logic                  resp_valid_o;
  logic [7:0]            stray_count_o;

  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] wdata_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  rw_o;
  logic                  valid_o;

  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic [DATA_WIDTH-1:0] rdata_i;
  logic                  rw_i;
  logic                  valid_i;

  modport master (
    input  req_addr_i, req_wdata_i, req_rw_i, req_valid_i,
    input  addr_i, wdata_i, rdata_i, rw_i, valid_i,
    output req_ready_o,
    output resp_rdata_o, resp_rw_o, resp_timeout_o, resp_valid_o, stray_count_o,
    output addr_o, wdata_o, rdata_o, rw_o, valid_o
  );

  modport slave (
    output req_addr_i, req_wdata_i, req_rw_i, req_valid_i,
    output addr_i, wdata_i, rdata_i, rw_i, valid_i,
    input  req_ready_o,
    input  resp_rdata_o, resp_rw_o, resp_timeout_o, resp_valid_o, stray_count_o,
    input  addr_o, wdata_o, rdata_o, rw_o, valid_o
  );

endinterface

// File: rtl/bus_initiator.sv
// Initiator end of the daisy-chained core bus: issues one transaction at a
// time, waits for it to return at the chain end, and reports data or timeout.
module bus_initiator #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            rst,
  bus_initiator_if.master bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  // WAIT starts counting at 0, so the last count before expiry is T-2.
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 2);
  localparam logic [7:0]       STRAY_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rw_q, rw_d;
  logic                  valid_q, valid_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_rw_q, resp_rw_d;
  logic                  resp_timeout_q, resp_timeout_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [7:0]            stray_q, stray_d;

  logic busy;
  logic accept;
  logic match;
  logic stray;

  // Return classification against the outstanding transaction
  always_comb begin
    busy   = (state_q == ISSUE) || (state_q == WAIT);
    accept = (state_q == IDLE) && ready_q && bus.req_valid_i;
    match  = busy && bus.valid_i && (bus.addr_i == addr_q) && (bus.rw_i == rw_q);
    stray  = bus.valid_i && !match;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rw_d           = rw_q;
    valid_d        = 1'b0;
    ready_d        = 1'b0;
    resp_rdata_d   = resp_rdata_q;
    resp_rw_d      = resp_rw_q;
    resp_timeout_d = resp_timeout_q;
    resp_valid_d   = 1'b0;
    stray_d        = (stray && (stray_q != STRAY_MAX)) ? stray_q + 8'd1 : stray_q;

    case (state_q)
      IDLE: begin
        ready_d = !accept;
        if (accept) begin
          addr_d  = bus.req_addr_i;
          wdata_d = bus.req_wdata_i;
          rw_d    = bus.req_rw_i;
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
        if (match) begin
          resp_valid_d   = 1'b1;
          resp_timeout_d = 1'b0;
          resp_rw_d      = rw_q;
          resp_rdata_d   = rw_q ? bus.wdata_i : bus.rdata_i;
          state_d        = IDLE;
        end
      end

      WAIT: begin
        // A return on the expiry cycle still completes normally
        if (match) begin
          resp_valid_d   = 1'b1;
          resp_timeout_d = 1'b0;
          resp_rw_d      = rw_q;
          resp_rdata_d   = rw_q ? bus.wdata_i : bus.rdata_i;
          state_d        = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          resp_valid_d   = 1'b1;
          resp_timeout_d = 1'b1;
          resp_rw_d      = rw_q;
          resp_rdata_d   = '0;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rw_q           <= 1'b0;
      valid_q        <= 1'b0;
      ready_q        <= 1'b0;
      resp_rdata_q   <= '0;
      resp_rw_q      <= 1'b0;
      resp_timeout_q <= 1'b0;
      resp_valid_q   <= 1'b0;
      stray_q        <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rw_q           <= rw_d;
      valid_q        <= valid_d;
      ready_q        <= ready_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_rw_q      <= resp_rw_d;
      resp_timeout_q <= resp_timeout_d;
      resp_valid_q   <= resp_valid_d;
      stray_q        <= stray_d;
    end
  end

  // Latched request doubles as the held bus command
  assign bus.addr_o         = addr_q;
  assign bus.wdata_o        = wdata_q;
  assign bus.rdata_o        = '0;
  assign bus.rw_o           = rw_q;
  assign bus.valid_o        = valid_q;
  assign bus.req_ready_o    = ready_q;
  assign bus.resp_rdata_o   = resp_rdata_q;
  assign bus.resp_rw_o      = resp_rw_q;
  assign bus.resp_timeout_o = resp_timeout_q;
  assign bus.resp_valid_o   = resp_valid_q;
  assign bus.stray_count_o  = stray_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator: bram/loopback/silent chain model with injectable
// returns, and a response scoreboard.
module tb_bus_initiator;

  localparam int M_BRAM   = 0;
  localparam int M_LOOP   = 1;
  localparam int M_SILENT = 2;

  typedef struct packed {
    logic        v;
    logic [15:0] a;
    logic [15:0] wd;
    logic [15:0] rd;
    logic        rw;
  } ret_t;

  typedef struct packed {
    logic        to;
    logic        rw;
    logic [15:0] rd;
  } exp_t;

  logic clk;
  logic rst;

  bus_initiator_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bif ();

  bus_initiator #(
    .ADDR_WIDTH    (16),
    .DATA_WIDTH    (16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif.master)
  );

  int n_chk  = 0;
  int n_pass = 0;

  int          mode;
  int          delay;
  logic        inj_v;
  logic [15:0] inj_a;
  logic [15:0] inj_rd;
  logic        inj_rw;

  logic [15:0] mem [0:255];
  ret_t        cur;
  ret_t        ret;
  ret_t        pipe [0:15];
  exp_t        sb [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Chain model: bram or loopback with programmable return delay
  always_comb begin
    cur.v  = bif.valid_o;
    cur.a  = bif.addr_o;
    cur.wd = bif.wdata_o;
    cur.rw = bif.rw_o;
    cur.rd = (mode == M_BRAM) ? mem[bif.addr_o[7:0]] : 16'h0;
    ret    = (delay == 0) ? cur : pipe[delay-1];
    if (mode == M_SILENT) ret.v = 1'b0;
    if (inj_v) ret = {1'b1, inj_a, 16'h0, inj_rd, inj_rw};
    bif.valid_i = ret.v;
    bif.addr_i  = ret.a;
    bif.wdata_i = ret.wd;
    bif.rdata_i = ret.rd;
    bif.rw_i    = ret.rw;
  end

  always @(posedge clk) begin
    if (cur.v && cur.rw && mode == M_BRAM) mem[cur.a[7:0]] <= cur.wd;
    pipe[0] <= cur;
    for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
  end

  // Response scoreboard
  always @(negedge clk) begin
    if (bif.resp_valid_o) begin
      if (sb.size() == 0) begin
        chk_eq("resp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk_eq("resp_timeout", 32'(bif.resp_timeout_o), 32'(e.to));
        chk_eq("resp_rw",      32'(bif.resp_rw_o),      32'(e.rw));
        chk_eq("resp_rdata",   32'(bif.resp_rdata_o),   32'(e.rd));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_resp(input logic to, input logic rw, input logic [15:0] rd);
    sb.push_back({to, rw, rd});
  endtask

  // Drive one request; returns one cycle after the accepting edge
  task automatic send(input logic [15:0] a, input logic [15:0] wd, input logic rw);
    int t = 0;
    while (!bif.req_ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk_eq("ready_wait", 32'd0, 32'd1);
    bif.req_addr_i  = a;
    bif.req_wdata_i = wd;
    bif.req_rw_i    = rw;
    bif.req_valid_i = 1'b1;
    @(negedge clk);
    bif.req_valid_i = 1'b0;
  endtask

  task automatic wait_resp(input string tag);
    int t = 0;
    while (!bif.resp_valid_o && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) chk_eq(tag, 32'd0, 32'd1);
    else @(negedge clk);
  endtask

  task automatic set_chain(input int m, input int d);
    mode = M_SILENT;
    step(20);
    mode  = m;
    delay = d;
    step(1);
  endtask

  task automatic inject(input logic [15:0] a, input logic rw, input logic [15:0] rd);
    inj_a  = a;
    inj_rw = rw;
    inj_rd = rd;
    inj_v  = 1'b1;
    @(negedge clk);
    inj_v  = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    mode            = M_BRAM;
    delay           = 1;
    inj_v           = 1'b0;
    inj_a           = '0;
    inj_rd          = '0;
    inj_rw          = 1'b0;
    bif.req_addr_i  = '0;
    bif.req_wdata_i = '0;
    bif.req_rw_i    = 1'b0;
    bif.req_valid_i = 1'b0;

    // Reset state
    step(3);
    chk_eq("rst_ready", 32'(bif.req_ready_o),   32'd0);
    chk_eq("rst_rvalid", 32'(bif.resp_valid_o), 32'd0);
    chk_eq("rst_valid", 32'(bif.valid_o),       32'd0);
    chk_eq("rst_addr",  32'(bif.addr_o),        32'd0);
    chk_eq("rst_stray", 32'(bif.stray_count_o), 32'd0);
    chk_eq("rst_rdata_o", 32'(bif.rdata_o),     32'd0);
    rst = 1'b0;
    step(1);
    chk_eq("ready_after_rst", 32'(bif.req_ready_o), 32'd1);

    // Write then read through a bram chain
    expect_resp(1'b0, 1'b1, 16'h0004); send(16'h0000, 16'h0004, 1'b1); wait_resp("wr0_resp");
    expect_resp(1'b0, 1'b0, 16'h0004); send(16'h0000, 16'h0000, 1'b0); wait_resp("rd0_resp");
    expect_resp(1'b0, 1'b1, 16'h0003); send(16'h0001, 16'h0003, 1'b1); wait_resp("wr1_resp");
    expect_resp(1'b0, 1'b0, 16'h0003); send(16'h0001, 16'h0000, 1'b0); wait_resp("rd1_resp");

    // Zero-delay loopback, back-to-back request held through busy cycles
    set_chain(M_LOOP, 0);
    expect_resp(1'b0, 1'b0, 16'h0000);
    expect_resp(1'b0, 1'b1, 16'hBEEF);
    send(16'h1234, 16'h0000, 1'b0);
    chk_eq("lb_issue_valid", 32'(bif.valid_o),     32'd1);
    chk_eq("lb_issue_addr",  32'(bif.addr_o),      32'h1234);
    chk_eq("lb_issue_ready", 32'(bif.req_ready_o), 32'd0);
    bif.req_addr_i  = 16'h0042;
    bif.req_wdata_i = 16'hBEEF;
    bif.req_rw_i    = 1'b1;
    bif.req_valid_i = 1'b1;
    step(1);
    chk_eq("lb_strobe",       32'(bif.resp_valid_o), 32'd1);
    chk_eq("lb_strobe_ready", 32'(bif.req_ready_o),  32'd0);
    chk_eq("lb_strobe_valid", 32'(bif.valid_o),      32'd0);
    step(1);
    chk_eq("lb_idle_ready", 32'(bif.req_ready_o),  32'd1);
    chk_eq("lb_idle_rv",    32'(bif.resp_valid_o), 32'd0);
    step(1);
    chk_eq("b2b_valid", 32'(bif.valid_o), 32'd1);
    chk_eq("b2b_addr",  32'(bif.addr_o),  32'h0042);
    chk_eq("b2b_rw",    32'(bif.rw_o),    32'd1);
    bif.req_valid_i = 1'b0;
    wait_resp("b2b_resp");

    // Chain that never returns
    set_chain(M_SILENT, 0);
    expect_resp(1'b1, 1'b0, 16'h0000);
    send(16'h0010, 16'h0000, 1'b0);
    chk_eq("to_issue", 32'(bif.valid_o), 32'd1);
    step(7);
    chk_eq("to_early", 32'(bif.resp_valid_o), 32'd0);
    step(1);
    chk_eq("to_strobe",       32'(bif.resp_valid_o), 32'd1);
    chk_eq("to_strobe_ready", 32'(bif.req_ready_o),  32'd0);
    step(1);
    chk_eq("to_ready_after", 32'(bif.req_ready_o), 32'd1);

    // Return on the expiry cycle completes normally
    set_chain(M_BRAM, 7);
    chk_eq("stray_before_exp", 32'(bif.stray_count_o), 32'd0);
    expect_resp(1'b0, 1'b0, 16'h0004);
    send(16'h0000, 16'h0000, 1'b0);
    step(8);
    chk_eq("exp_match_strobe", 32'(bif.resp_valid_o), 32'd1);
    step(1);

    // One cycle later: timeout, and the late return is a stray
    set_chain(M_BRAM, 8);
    expect_resp(1'b1, 1'b0, 16'h0000);
    send(16'h0001, 16'h0000, 1'b0);
    step(8);
    chk_eq("late_to_strobe", 32'(bif.resp_valid_o), 32'd1);
    step(1);
    chk_eq("late_stray", 32'(bif.stray_count_o), 32'd1);

    // Strays
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    set_chain(M_SILENT, 0);
    chk_eq("stray_cleared", 32'(bif.stray_count_o), 32'd0);
    inject(16'h0055, 1'b0, 16'h0000);
    chk_eq("stray_idle", 32'(bif.stray_count_o), 32'd1);
    expect_resp(1'b0, 1'b0, 16'h5A5A);
    send(16'h0020, 16'h0000, 1'b0);
    step(1);
    inject(16'h0021, 1'b0, 16'h1111);
    chk_eq("stray_wait",    32'(bif.stray_count_o), 32'd2);
    chk_eq("stray_no_resp", 32'(bif.resp_valid_o),  32'd0);
    inject(16'h0020, 1'b0, 16'h5A5A);
    chk_eq("stray_then_match", 32'(bif.resp_valid_o),  32'd1);
    chk_eq("stray_match_cnt",  32'(bif.stray_count_o), 32'd2);
    step(2);
    inj_a  = 16'h0099;
    inj_rw = 1'b1;
    inj_v  = 1'b1;
    step(300);
    inj_v = 1'b0;
    step(1);
    chk_eq("stray_saturate", 32'(bif.stray_count_o), 32'd255);

    // Reset while a transaction is outstanding
    send(16'h0007, 16'h0000, 1'b0);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(3);
    inject(16'h0007, 1'b0, 16'h7777);
    chk_eq("rst_mid_stray", 32'(bif.stray_count_o), 32'd1);
    chk_eq("rst_mid_rv",    32'(bif.resp_valid_o),  32'd0);
    chk_eq("rst_mid_ready", 32'(bif.req_ready_o),   32'd1);

    step(5);
    chk_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
